// File: rtl/traffic_phase_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_timer_pkg
// Description : Shared definitions for the traffic phase timer.
//               - state_t     : timer state encoding (IDLE / RUN / HOLD)
//               - dur_default : power-on duration per table index
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned c_dur_idx0 = 20;
  localparam int unsigned c_dur_idx1 = 5;
  localparam int unsigned c_dur_idx2 = 25;
  localparam int unsigned c_dur_idx3 = 2;

  // Indices beyond the four named phases reset to a one-cycle duration.
  function automatic int unsigned dur_default(input int unsigned idx);
    case (idx)
      0:       dur_default = c_dur_idx0;
      1:       dur_default = c_dur_idx1;
      2:       dur_default = c_dur_idx2;
      3:       dur_default = c_dur_idx3;
      default: dur_default = 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_timer_if
// Description : Control/status bundle of the traffic phase timer.
//   master : drives start, timer_select, hold, cfg_we, cfg_addr, cfg_data;
//            observes done_pulse, busy, remaining, cur_select
//   slave  : the timer side (directions reversed)
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8,
  parameter int SEL_W = 2
);
  logic             start;
  logic [SEL_W-1:0] timer_select;
  logic             hold;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic             done_pulse;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic [SEL_W-1:0] cur_select;

  modport master (
    output start, timer_select, hold, cfg_we, cfg_addr, cfg_data,
    input  done_pulse, busy, remaining, cur_select
  );

  modport slave (
    input  start, timer_select, hold, cfg_we, cfg_addr, cfg_data,
    output done_pulse, busy, remaining, cur_select
  );
endinterface
`default_nettype wire

// File: rtl/phase_dur_table.sv
`default_nettype none
// ============================================================================
// Module      : phase_dur_table
// Description : Phase duration table, registered write / combinational read.
//   clk, rst : clock, asynchronous active-low reset (loads defaults)
//   we, waddr, wdata : write port
//   raddr, rdata     : read port (returns the pre-write value on a
//                      same-edge write, as the write lands at the edge)
// Revision    : 1.0 - initial release
// ============================================================================
module phase_dur_table
  import traffic_timer_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SEL_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             we,
  input  wire logic [SEL_W-1:0] waddr,
  input  wire logic [CNT_W-1:0] wdata,
  input  wire logic [SEL_W-1:0] raddr,
  output logic      [CNT_W-1:0] rdata
);
  localparam int NUM_SEL = 2**SEL_W;

  logic [CNT_W-1:0] r_table [NUM_SEL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SEL; i++) begin
        r_table[i] <= CNT_W'(dur_default(i));
      end
    end else if (we) begin
      r_table[waddr] <= wdata;
    end
  end

  assign rdata = r_table[raddr];

endmodule
`default_nettype wire

// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_timer
// Description : Programmable phase timer with hold, restart and optional
//               periodic reload.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of traffic_phase_timer_if
//          inputs  start, timer_select, hold, cfg_we, cfg_addr, cfg_data
//          outputs done_pulse, busy, remaining, cur_select (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_timer
  import traffic_timer_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SEL_W       = 2,
  parameter int AUTO_RELOAD = 1
) (
  input wire logic              clk,
  input wire logic              rst,
  traffic_phase_timer_if.slave  bus
);
  state_t           r_state;
  logic             r_done;
  logic             r_busy;
  logic [CNT_W-1:0] r_remaining;
  logic [SEL_W-1:0] r_cur_select;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_load_val;

  phase_dur_table #(
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (bus.timer_select),
    .rdata (w_dur)
  );

  // A count of D-1 after the load edge makes terminal count land D edges
  // later. A stored 0 behaves as 1, i.e. loads 0.
  assign w_load_val = (w_dur == '0) ? '0 : w_dur - 1'b1;

  // HOLD with hold low behaves exactly like RUN (counts on that edge), so
  // only edges that actually sample hold high are lost to the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_remaining  <= '0;
      r_cur_select <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_state      <= ST_RUN;
        r_busy       <= 1'b1;
        r_remaining  <= w_load_val;
        r_cur_select <= bus.timer_select;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_RUN, ST_HOLD: begin
            if (bus.hold) begin
              r_state <= ST_HOLD;
            end else if (r_remaining == '0) begin
              r_done <= 1'b1;
              if (AUTO_RELOAD != 0) begin
                r_state      <= ST_RUN;
                r_remaining  <= w_load_val;
                r_cur_select <= bus.timer_select;
              end else begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_remaining <= '0;
              end
            end else begin
              r_state     <= ST_RUN;
              r_remaining <= r_remaining - 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.done_pulse = r_done;
  assign bus.busy       = r_busy;
  assign bus.remaining  = r_remaining;
  assign bus.cur_select = r_cur_select;

endmodule
`default_nettype wire
